// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size codes, FSM states,
// completion cause codes and the store lane-placement helpers.
package mem_stage_pkg;

   // funct3 access size / sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } stateT;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_BUSERR   = 2'b10,
      CAUSE_TIMEOUT  = 2'b11
   } causeT;

   // Halfwords need an even address, words (and unused size codes) a word-aligned one.
   function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
      logic bad;
      case (funct3[1:0])
         2'b00:   bad = 1'b0;
         2'b01:   bad = addrLow[0];
         default: bad = (addrLow != 2'b00);
      endcase
      isMisaligned = bad;
   endfunction

   // Byte strobes for a store of the given size at the given byte offset.
   function automatic logic [3:0] storeStrobe(input logic [2:0] funct3, input logic [1:0] addrLow);
      logic [3:0] strb;
      case (funct3[1:0])
         2'b00:   strb = 4'b0001 << addrLow;
         2'b01:   strb = 4'b0011 << addrLow;
         default: strb = 4'b1111;
      endcase
      storeStrobe = strb;
   endfunction

   // Store data replicated across all lanes so the strobes pick the right copy.
   function automatic logic [31:0] storeData(input logic [2:0] funct3, input logic [31:0] rs2);
      logic [31:0] data;
      case (funct3[1:0])
         2'b00:   data = {4{rs2[7:0]}};
         2'b01:   data = {2{rs2[15:0]}};
         default: data = rs2;
      endcase
      storeData = data;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_stage_if #(
   parameter int ADDR_W = 32
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic              mem_err;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_err, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_err, mem_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of the
// read word and sign- or zero-extends it; words pass through unchanged.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  lane [4];
   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
   end

   assign byteSel = lane[addr];
   assign halfSel = addr[1] ? rdata[31:16] : rdata[15:0];

   // Extend the selected field according to the access size and signedness.
   always_comb begin
      value = rdata;
      case (funct3)
         F3_B:    value = {{24{byteSel[7]}}, byteSel};
         F3_H:    value = {{16{halfSel[15]}}, halfSel};
         F3_BU:   value = {24'd0, byteSel};
         F3_HU:   value = {16'd0, halfSel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU ops pass through with one cycle of latency,
// aligned loads/stores hold the pipe while a single bus request is
// outstanding, and misaligned, errored or timed-out accesses complete with a
// cause code and no register write. TIMEOUT must be at least 1.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int ADDR_W  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_RegWrite,
   input  logic        in_MemToReg,
   input  logic [4:0]  in_RegDest,
   input  logic [31:0] in_result,
   input  logic [31:0] in_rs2_value,
   input  logic [2:0]  in_funct3,
   output logic        stall,
   mem_stage_if.master bus,
   output logic        out_valid,
   output logic        out_RegWrite,
   output logic        out_MemToReg,
   output logic [4:0]  out_RegDest,
   output logic [31:0] out_read_data,
   output logic [31:0] out_alu_result,
   output logic [1:0]  out_cause
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_REQ_CNT = CNT_W'(TIMEOUT - 1);

   stateT             stateReg;
   logic [CNT_W-1:0]  cntReg;

   // bus-side registers, held stable for the whole request
   logic              memReqReg;
   logic              memWeReg;
   logic [ADDR_W-1:0] memAddrReg;
   logic [31:0]       memWdataReg;
   logic [3:0]        memWstrbReg;

   // captured instruction context for the access in flight
   logic [2:0]        funct3Reg;
   logic [1:0]        addrLowReg;
   logic [4:0]        destReg;
   logic              regWriteReg;
   logic              memToRegReg;
   logic              isLoadReg;
   logic [31:0]       resultReg;

   // writeback-side registers
   logic              outValidReg;
   logic              outRegWriteReg;
   logic              outMemToRegReg;
   logic [4:0]        outRegDestReg;
   logic [31:0]       outReadDataReg;
   logic [31:0]       outAluResultReg;
   logic [1:0]        outCauseReg;

   logic              isMemOp;
   logic              isStore;
   logic              isLoad;
   logic              misaligned;
   logic              timedOut;
   logic              busDone;
   logic [ADDR_W-1:0] addrFull;
   logic [31:0]       loadValue;

   // Both MemRead and MemWrite set is a store.
   assign isStore    = in_MemWrite;
   assign isLoad     = in_MemRead && !in_MemWrite;
   assign isMemOp    = in_MemRead || in_MemWrite;
   assign misaligned = isMemOp && isMisaligned(in_funct3, in_result[1:0]);
   assign addrFull   = ADDR_W'(in_result);

   // The timeout cycle has mem_req already low, so a late ready there is ignored.
   assign timedOut = (stateReg == REQ) && (cntReg == TIMEOUT_CNT);
   assign busDone  = (stateReg == REQ) && !timedOut && bus.mem_ready;

   mem_load_align u_align (
      .rdata  (bus.mem_rdata),
      .addr   (addrLowReg),
      .funct3 (funct3Reg),
      .value  (loadValue)
   );

   // Hold upstream while an aligned access is being issued or is outstanding.
   always_comb begin
      stall = 1'b0;
      case (stateReg)
         IDLE:    stall = in_valid && isMemOp && !misaligned;
         REQ:     stall = !busDone && !timedOut;
         default: stall = 1'b0;
      endcase
   end

   // Request FSM, bus registers and writeback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg        <= IDLE;
         cntReg          <= '0;
         memReqReg       <= 1'b0;
         memWeReg        <= 1'b0;
         memAddrReg      <= '0;
         memWdataReg     <= '0;
         memWstrbReg     <= '0;
         funct3Reg       <= '0;
         addrLowReg      <= '0;
         destReg         <= '0;
         regWriteReg     <= 1'b0;
         memToRegReg     <= 1'b0;
         isLoadReg       <= 1'b0;
         resultReg       <= '0;
         outValidReg     <= 1'b0;
         outRegWriteReg  <= 1'b0;
         outMemToRegReg  <= 1'b0;
         outRegDestReg   <= '0;
         outReadDataReg  <= '0;
         outAluResultReg <= '0;
         outCauseReg     <= CAUSE_NONE;
      end else begin
         outValidReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (in_valid) begin
                  if (!isMemOp || misaligned) begin
                     outValidReg     <= 1'b1;
                     outRegWriteReg  <= in_RegWrite && !misaligned;
                     outMemToRegReg  <= in_MemToReg;
                     outRegDestReg   <= in_RegDest;
                     outReadDataReg  <= '0;
                     outAluResultReg <= in_result;
                     outCauseReg     <= misaligned ? CAUSE_MISALIGN : CAUSE_NONE;
                  end else begin
                     stateReg    <= REQ;
                     cntReg      <= '0;
                     memReqReg   <= 1'b1;
                     memWeReg    <= isStore;
                     memAddrReg  <= {addrFull[ADDR_W-1:2], 2'b00};
                     memWdataReg <= isStore ? storeData(in_funct3, in_rs2_value) : 32'd0;
                     memWstrbReg <= isStore ? storeStrobe(in_funct3, in_result[1:0]) : 4'b0000;
                     funct3Reg   <= in_funct3;
                     addrLowReg  <= in_result[1:0];
                     destReg     <= in_RegDest;
                     regWriteReg <= in_RegWrite;
                     memToRegReg <= in_MemToReg;
                     isLoadReg   <= isLoad;
                     resultReg   <= in_result;
                  end
               end
            end
            REQ: begin
               if (timedOut || busDone) begin
                  stateReg        <= IDLE;
                  memReqReg       <= 1'b0;
                  outValidReg     <= 1'b1;
                  outMemToRegReg  <= memToRegReg;
                  outRegDestReg   <= destReg;
                  outAluResultReg <= resultReg;
                  if (timedOut) begin
                     outRegWriteReg <= 1'b0;
                     outReadDataReg <= '0;
                     outCauseReg    <= CAUSE_TIMEOUT;
                  end else if (bus.mem_err) begin
                     outRegWriteReg <= 1'b0;
                     outReadDataReg <= '0;
                     outCauseReg    <= CAUSE_BUSERR;
                  end else begin
                     outRegWriteReg <= regWriteReg;
                     outReadDataReg <= isLoadReg ? loadValue : 32'd0;
                     outCauseReg    <= CAUSE_NONE;
                  end
               end else begin
                  cntReg <= cntReg + 1'b1;
                  // mem_req drops as the counter steps onto TIMEOUT
                  if (cntReg == LAST_REQ_CNT) begin
                     memReqReg <= 1'b0;
                  end
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = memReqReg;
   assign bus.mem_we    = memWeReg;
   assign bus.mem_addr  = memAddrReg;
   assign bus.mem_wdata = memWdataReg;
   assign bus.mem_wstrb = memWstrbReg;

   assign out_valid      = outValidReg;
   assign out_RegWrite   = outRegWriteReg;
   assign out_MemToReg   = outMemToRegReg;
   assign out_RegDest    = outRegDestReg;
   assign out_read_data  = outReadDataReg;
   assign out_alu_result = outAluResultReg;
   assign out_cause      = outCauseReg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors with a
// small bus responder, plus hand sequences for reset and stray-ready cases.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg;
   logic [4:0]  in_RegDest;
   logic [31:0] in_result, in_rs2_value;
   logic [2:0]  in_funct3;
   logic        stall;
   logic        out_valid, out_RegWrite, out_MemToReg;
   logic [4:0]  out_RegDest;
   logic [31:0] out_read_data, out_alu_result;
   logic [1:0]  out_cause;

   int assertions = 0;
   int failures   = 0;

   mem_stage_if #(.ADDR_W(32)) bus ();

   mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_MemRead     (in_MemRead),
      .in_MemWrite    (in_MemWrite),
      .in_RegWrite    (in_RegWrite),
      .in_MemToReg    (in_MemToReg),
      .in_RegDest     (in_RegDest),
      .in_result      (in_result),
      .in_rs2_value   (in_rs2_value),
      .in_funct3      (in_funct3),
      .stall          (stall),
      .bus            (bus),
      .out_valid      (out_valid),
      .out_RegWrite   (out_RegWrite),
      .out_MemToReg   (out_MemToReg),
      .out_RegDest    (out_RegDest),
      .out_read_data  (out_read_data),
      .out_alu_result (out_alu_result),
      .out_cause      (out_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        memRead, memWrite, regWrite, memToReg;
      logic [4:0]  dest;
      logic [31:0] result, rs2;
      logic [2:0]  f3;
      int          readyAt;   // REQ cycle (1-based) on which ready is given, 0 = never
      logic        err;
      logic [31:0] rdata;
      int          expStall, expReq;
      logic [31:0] expAddr;
      logic        expWe;
      logic [3:0]  expWstrb;
      logic [31:0] expWdata;
      logic        expRegWrite;
      logic [31:0] expReadData;
      logic [1:0]  expCause;
   } vecT;

   function automatic vecT mk(
      input string nm, input logic mr, input logic mw, input logic rw, input logic m2r,
      input logic [4:0] d, input logic [31:0] res, input logic [31:0] rs2, input logic [2:0] f3,
      input int rdy, input logic err, input logic [31:0] rdata,
      input int eStall, input int eReq, input logic [31:0] eAddr, input logic eWe,
      input logic [3:0] eStrb, input logic [31:0] eWd, input logic eRw,
      input logic [31:0] eRd, input logic [1:0] eCause);
      vecT v;
      v.name = nm; v.memRead = mr; v.memWrite = mw; v.regWrite = rw; v.memToReg = m2r;
      v.dest = d; v.result = res; v.rs2 = rs2; v.f3 = f3; v.readyAt = rdy; v.err = err;
      v.rdata = rdata; v.expStall = eStall; v.expReq = eReq; v.expAddr = eAddr; v.expWe = eWe;
      v.expWstrb = eStrb; v.expWdata = eWd; v.expRegWrite = eRw; v.expReadData = eRd;
      v.expCause = eCause;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one instruction at posedge+1, answer the bus, then check writeback.
   task automatic runVec(input vecT v);
      int  stallCycles = 0;
      int  reqCycles   = 0;
      bit  consumed    = 0;
      bit  sawReq      = 0;
      in_valid     = 1'b1;
      in_MemRead   = v.memRead;
      in_MemWrite  = v.memWrite;
      in_RegWrite  = v.regWrite;
      in_MemToReg  = v.memToReg;
      in_RegDest   = v.dest;
      in_result    = v.result;
      in_rs2_value = v.rs2;
      in_funct3    = v.f3;
      for (int c = 0; c < 40 && !consumed; c++) begin
         @(negedge clk);
         if (bus.mem_req) begin
            reqCycles++;
            if (!sawReq) begin
               check({v.name, " mem_addr"},  bus.mem_addr, v.expAddr);
               check({v.name, " mem_we"},    32'(bus.mem_we), 32'(v.expWe));
               check({v.name, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.expWstrb));
               check({v.name, " mem_wdata"}, bus.mem_wdata, v.expWdata);
            end
            sawReq = 1;
            if (reqCycles == v.readyAt) begin
               bus.mem_ready = 1'b1;
               bus.mem_err   = v.err;
               bus.mem_rdata = v.rdata;
            end
         end
         #1;
         if (stall) stallCycles++;
         else consumed = 1;
         @(posedge clk);
         #1;
         bus.mem_ready = 1'b0;
         bus.mem_err   = 1'b0;
      end
      in_valid = 1'b0;
      check({v.name, " consumed"},    32'(consumed), 32'd1);
      check({v.name, " stall cycles"}, stallCycles, v.expStall);
      check({v.name, " req cycles"},   reqCycles, v.expReq);
      check({v.name, " out_valid"},    32'(out_valid), 32'd1);
      check({v.name, " out_RegWrite"}, 32'(out_RegWrite), 32'(v.expRegWrite));
      check({v.name, " out_MemToReg"}, 32'(out_MemToReg), 32'(v.memToReg));
      check({v.name, " out_RegDest"},  32'(out_RegDest), 32'(v.dest));
      check({v.name, " out_read_data"}, out_read_data, v.expReadData);
      check({v.name, " out_alu_result"}, out_alu_result, v.result);
      check({v.name, " out_cause"},    32'(out_cause), 32'(v.expCause));
      @(posedge clk);
      #1;
      check({v.name, " out_valid pulse"}, 32'(out_valid), 32'd0);
      check({v.name, " mem_req idle"},    32'(bus.mem_req), 32'd0);
      $display("vec %s: stall=%0d req=%0d rd=0x%08h cause=%0d", v.name, stallCycles, reqCycles,
               out_read_data, out_cause);
   endtask

   vecT vecs [15];

   initial begin
      //            name       MR MW RW M2R dest result        rs2           f3     rdy err rdata
      //                       | stall req addr          we strb     wdata         RW rdata         cause
      vecs[0]  = mk("add",     0, 0, 1, 0, 5,  32'h10,       32'h0,        F3_W,  0, 0, 32'h0,
                               0, 0, 32'h0,   0, 4'b0000, 32'h0,        1, 32'h0,        2'b00);
      vecs[1]  = mk("sb103",   0, 1, 0, 0, 0,  32'h103,      32'hAB,       F3_B,  3, 0, 32'h0,
                               3, 3, 32'h100, 1, 4'b1000, 32'hABABABAB, 0, 32'h0,        2'b00);
      vecs[2]  = mk("lh202",   1, 0, 1, 1, 7,  32'h202,      32'h0,        F3_H,  1, 0, 32'h80011234,
                               1, 1, 32'h200, 0, 4'b0000, 32'h0,        1, 32'hFFFF8001, 2'b00);
      vecs[3]  = mk("lhu202",  1, 0, 1, 1, 7,  32'h202,      32'h0,        F3_HU, 1, 0, 32'h80011234,
                               1, 1, 32'h200, 0, 4'b0000, 32'h0,        1, 32'h00008001, 2'b00);
      vecs[4]  = mk("lw101",   1, 0, 1, 1, 8,  32'h101,      32'h0,        F3_W,  0, 0, 32'h0,
                               0, 0, 32'h0,   0, 4'b0000, 32'h0,        0, 32'h0,        2'b01);
      vecs[5]  = mk("sh22",    0, 1, 0, 0, 0,  32'h22,       32'h1234BEEF, F3_H,  2, 0, 32'h0,
                               2, 2, 32'h20,  1, 4'b1100, 32'hBEEFBEEF, 0, 32'h0,        2'b00);
      vecs[6]  = mk("sw40",    0, 1, 0, 0, 0,  32'h40,       32'hDEADBEEF, F3_W,  1, 0, 32'h0,
                               1, 1, 32'h40,  1, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        2'b00);
      vecs[7]  = mk("lb41",    1, 0, 1, 1, 9,  32'h41,       32'h0,        F3_B,  1, 0, 32'h11228300,
                               1, 1, 32'h40,  0, 4'b0000, 32'h0,        1, 32'hFFFFFF83, 2'b00);
      vecs[8]  = mk("lbu43",   1, 0, 1, 1, 10, 32'h43,       32'h0,        F3_BU, 2, 0, 32'hF0112233,
                               2, 2, 32'h40,  0, 4'b0000, 32'h0,        1, 32'h000000F0, 2'b00);
      vecs[9]  = mk("lwlate",  1, 0, 1, 1, 11, 32'h80,       32'h0,        F3_W,  4, 0, 32'hCAFEF00D,
                               4, 4, 32'h80,  0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 2'b00);
      vecs[10] = mk("lwerr",   1, 0, 1, 1, 12, 32'h84,       32'h0,        F3_W,  2, 1, 32'h12345678,
                               2, 2, 32'h84,  0, 4'b0000, 32'h0,        0, 32'h0,        2'b10);
      vecs[11] = mk("lwtmo",   1, 0, 1, 1, 13, 32'h88,       32'h0,        F3_W,  0, 0, 32'h0,
                               5, 4, 32'h88,  0, 4'b0000, 32'h0,        0, 32'h0,        2'b11);
      vecs[12] = mk("rdwr",    1, 1, 0, 1, 0,  32'h90,       32'h55,       F3_W,  1, 0, 32'hFFFFFFFF,
                               1, 1, 32'h90,  1, 4'b1111, 32'h55,       0, 32'h0,        2'b00);
      vecs[13] = mk("lh205",   1, 0, 1, 1, 14, 32'h205,      32'h0,        F3_H,  0, 0, 32'h0,
                               0, 0, 32'h0,   0, 4'b0000, 32'h0,        0, 32'h0,        2'b01);
      vecs[14] = mk("sb200",   0, 1, 0, 0, 0,  32'h200,      32'h12345678, F3_B,  1, 0, 32'h0,
                               1, 1, 32'h200, 1, 4'b0001, 32'h78787878, 0, 32'h0,        2'b00);

      rst = 1'b1;
      in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_RegWrite = 1'b0;
      in_MemToReg = 1'b0; in_RegDest = '0; in_result = '0; in_rs2_value = '0; in_funct3 = '0;
      bus.mem_ready = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      check("rst stall",      32'(stall), 32'd0);
      check("rst mem_req",    32'(bus.mem_req), 32'd0);
      check("rst mem_we",     32'(bus.mem_we), 32'd0);
      check("rst mem_wstrb",  32'(bus.mem_wstrb), 32'd0);
      check("rst mem_addr",   bus.mem_addr, 32'd0);
      check("rst mem_wdata",  bus.mem_wdata, 32'd0);
      check("rst out_valid",  32'(out_valid), 32'd0);
      check("rst out_RegWrite", 32'(out_RegWrite), 32'd0);
      check("rst out_cause",  32'(out_cause), 32'd0);
      check("rst out_read_data", out_read_data, 32'd0);
      check("rst out_alu_result", out_alu_result, 32'd0);
      $display("reset state checked");

      // stray ready while idle
      bus.mem_ready = 1'b1;
      #1;
      check("stray stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      check("stray out_valid", 32'(out_valid), 32'd0);
      check("stray mem_req",   32'(bus.mem_req), 32'd0);
      $display("stray ready checked");

      foreach (vecs[i]) runVec(vecs[i]);

      // reset while a load is outstanding
      in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0; in_RegWrite = 1'b1;
      in_MemToReg = 1'b1; in_RegDest = 5'd20; in_result = 32'hA0; in_funct3 = F3_W;
      @(posedge clk);
      #1;
      check("rstreq mem_req high", 32'(bus.mem_req), 32'd1);
      check("rstreq stall high",   32'(stall), 32'd1);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rstreq mem_req low",  32'(bus.mem_req), 32'd0);
      check("rstreq out_valid",    32'(out_valid), 32'd0);
      check("rstreq stall",        32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("rstreq out_valid after", 32'(out_valid), 32'd0);
      check("rstreq mem_req after",   32'(bus.mem_req), 32'd0);
      $display("reset during request checked");

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in REQ waiting for mem_ready.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the data-memory address width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  execute-stage instruction present.
REQ-006 in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg  input  1 each  control bits from execute.
REQ-007 in_RegDest  input  5  destination register.
REQ-008 in_result  input  32  ALU result; this is the address for loads and stores.
REQ-009 in_rs2_value  input  32  store data.
REQ-010 in_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 stall  output  1  upstream holds all inputs while high; an instruction is consumed on a cycle with in_valid && !stall.
REQ-012 mem_req, mem_we  output  1 each  data-bus request and write enable.
REQ-013 mem_addr  output  ADDR_W  word-aligned address (low 2 bits zero).
REQ-014 mem_wdata  output  32; mem_wstrb  output  4  store data and byte strobes.
REQ-015 mem_ready, mem_err  input  1 each  bus completion and bus error (mem_err is valid only with mem_ready).
REQ-016 mem_rdata  input  32  read word.
REQ-017 out_valid, out_RegWrite, out_MemToReg  output  1 each  registered results to writeback.
REQ-018 out_RegDest  output  5; out_read_data, out_alu_result  output  32 each.
REQ-019 out_cause  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout.

Function
REQ-020 SHALL implement the FSM states IDLE and REQ.
REQ-021 IDLE, in_valid, no memory op: stall=0; on the next edge out_valid=1 and the control fields and in_result are registered through (latency 1).
REQ-022 IDLE, in_valid, aligned memory op: stall=1; capture addr, wdata, wstrb, we, funct3 and dest; next state is REQ.
REQ-023 In REQ, mem_req=1 and all bus outputs SHALL stay stable until mem_ready.
REQ-024 In REQ, stall = !mem_ready; the instruction is consumed in the mem_ready cycle; next edge: out_valid=1, state IDLE, mem_req=0.
REQ-025 Misalignment is H with addr[0]=1, or W with addr[1:0]!=0; such an access SHALL raise no bus request, use stall=0, and on the next edge drive out_valid=1, out_cause=01, out_RegWrite=0.
REQ-026 Stores SHALL place data as follows.
- SB: wstrb=0001<<addr[1:0]; wdata={4{rs2[7:0]}}.
- SH: wstrb=0011<<addr[1:0]; wdata={2{rs2[15:0]}}.
- SW: wstrb=1111; wdata=rs2.
REQ-027 Loads SHALL select the byte or halfword by the captured addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU); W passes mem_rdata through unchanged.
REQ-028 mem_ready with mem_err=1 SHALL complete with out_cause=10 and out_RegWrite=0.
REQ-029 A cycle counter SHALL clear on REQ entry; when it reaches TIMEOUT without mem_ready: drop mem_req, stall=0 that cycle, out_cause=11, out_RegWrite=0, return to IDLE.
REQ-030 in_MemRead && in_MemWrite both set SHALL be treated as a store.
REQ-031 mem_ready asserted outside REQ SHALL be ignored.
REQ-032 out_valid SHALL be a one-cycle pulse per consumed instruction; with no consumption it SHALL be 0.

Reset
REQ-033 While rst=1 at a clock edge, the next state SHALL be: state IDLE; mem_req, mem_we, mem_wstrb, out_valid, out_RegWrite, out_MemToReg, out_cause, counter all 0; every data output 0.
REQ-034 rst during REQ SHALL abandon the access: mem_req=0 after that edge, no out_valid for the aborted instruction.
REQ-035 stall SHALL be 0 while state is IDLE and in_valid=0, which includes immediately after reset.

Structure
REQ-036 A shared package/header mem_stage_pkg SHALL hold the funct3 size codes, the state encodings and the out_cause codes.
REQ-037 The load extract/extend logic SHALL be a combinational sub-module mem_load_align (inputs rdata, addr[1:0], funct3; output 32-bit value).

Verification
REQ-038 ADD, result=0x10, RegWrite=1, in_valid one cycle -> stall=0; next cycle out_valid=1, out_alu_result=0x10.
REQ-039 SB addr=0x103, rs2=0xAB, mem_ready after 3 cycles -> mem_addr=0x100, wstrb=1000, wdata=0xABABABAB, stall high 3 cycles, then out_valid=1.
REQ-040 LH addr=0x202, mem_rdata=0x8001_1234, ready on the first REQ cycle -> out_read_data=0xFFFF8001; the same access as LHU -> 0x00008001.
REQ-041 LW addr=0x101 -> no mem_req, out_cause=01, out_RegWrite=0, stall never high.
REQ-042 LW with TIMEOUT=4 and mem_ready held 0 -> mem_req high 4 cycles then low, out_cause=11; then rst asserted during a new REQ -> mem_req=0 next cycle, no out_valid.
